// File: rtl/hazard_stall_unit_pkg.sv
// Shared CPU pipeline-control definitions: FSM state encoding, register
// address width default and the hard-wired zero register.
package hazard_stall_unit_pkg;

  localparam int REG_ADDR_W_DEF = 4;
  localparam int ZERO_REG       = 0;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_stall_unit_hazard_detect.sv
// Load-use comparator: flags an ID instruction reading the destination of a load in EX.
// Purely combinational, zero latency; no flow control.
module hazard_detect
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic                  load_use
);

  logic rd_nonzero;
  logic rs_match;
  logic rt_match;

  assign rd_nonzero = (ex_rd != REG_ADDR_W'(ZERO_REG));
  assign rs_match   = (ex_rd == id_rs);
  assign rt_match   = id_uses_rt & (ex_rd == id_rt);
  assign load_use   = ex_mem_read & rd_nonzero & (rs_match | rt_match);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline lock/bubble/flush control for load-use, multi-cycle EX ops and taken branches.
// Outputs are combinational from state and inputs (zero latency); no handshake, stalls are imposed.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_mul_start,
  input  logic                  branch_taken,
  output logic                  pc_dis,
  output logic                  ifid_dis,
  output logic                  idex_dis,
  output logic                  idex_bubble,
  output logic                  flush,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_flush_q, pend_flush_d;
  logic             load_use;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_flush_d = pend_flush_q;
    pc_dis       = 1'b0;
    ifid_dis     = 1'b0;
    idex_dis     = 1'b0;
    idex_bubble  = 1'b0;
    flush        = 1'b0;
    busy         = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          // A branch taken while the front was frozen is honoured on the first free cycle.
          if (pend_flush_q) begin
            flush        = 1'b1;
            idex_bubble  = 1'b1;
            pend_flush_d = 1'b0;
          end else if (branch_taken) begin
            flush       = 1'b1;
            idex_bubble = 1'b1;
          end else if (ex_mul_start) begin
            pc_dis   = 1'b1;
            ifid_dis = 1'b1;
            idex_dis = 1'b1;
            busy     = 1'b1;
            state_d  = ST_MUL_WAIT;
            cnt_d    = CNT_LOAD;
          end else if (load_use) begin
            pc_dis      = 1'b1;
            ifid_dis    = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        ST_MUL_WAIT: begin
          pc_dis   = 1'b1;
          ifid_dis = 1'b1;
          idex_dis = 1'b1;
          busy     = 1'b1;
          if (branch_taken) begin
            pend_flush_d = 1'b1;
          end
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pend_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_flush_q <= pend_flush_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic
// compared every cycle against a cycle-count behavioural model.
module tb_hazard_stall_unit;

  localparam int AW = 4;
  localparam int MC = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rd;
  logic          id_uses_rt, ex_mem_read, ex_mul_start, branch_taken;
  logic          pc_dis, ifid_dis, idex_dis, idex_bubble, flush, busy;

  int checks = 0;
  int errors = 0;

  // Model state: stall cycles still owed after the start cycle, and a deferred flush.
  int model_rem  = 0;
  bit model_pend = 0;

  hazard_stall_unit #(
    .REG_ADDR_W (AW),
    .MUL_CYCLES (MC),
    .CNT_W      (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_mul_start (ex_mul_start),
    .branch_taken (branch_taken),
    .pc_dis       (pc_dis),
    .ifid_dis     (ifid_dis),
    .idex_dis     (idex_dis),
    .idex_bubble  (idex_bubble),
    .flush        (flush),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] dut_vec();
    return {pc_dis, ifid_dis, idex_dis, idex_bubble, flush, busy};
  endfunction

  function automatic bit model_load_use();
    return ex_mem_read && (ex_rd != 0) &&
           ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  endfunction

  // Expected {pc_dis, ifid_dis, idex_dis, idex_bubble, flush, busy} for this cycle.
  function automatic logic [5:0] model_vec();
    if (rst)             return 6'b000000;
    if (model_rem > 0)   return 6'b111001;
    if (model_pend)      return 6'b000110;
    if (branch_taken)    return 6'b000110;
    if (ex_mul_start)    return 6'b111001;
    if (model_load_use()) return 6'b110100;
    return 6'b000000;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_rem  = 0;
      model_pend = 0;
    end else if (model_rem > 0) begin
      if (branch_taken) model_pend = 1;
      model_rem = model_rem - 1;
    end else if (model_pend) begin
      model_pend = 0;
    end else if (!branch_taken && ex_mul_start) begin
      model_rem = MC - 1;
    end
  end

  always @(negedge clk) begin
    logic [5:0] exp_v;
    logic [5:0] got_v;
    exp_v = model_vec();
    got_v = dut_vec();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, got_v, exp_v);
    end
  end

  task automatic lit(input string name, input logic [5:0] exp_v);
    logic [5:0] got_v;
    got_v = dut_vec();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got_v, exp_v);
    end
  endtask

  task automatic step(input logic r, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic urt, input logic [AW-1:0] rd, input logic mr,
                      input logic ms, input logic bt);
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_rd = rd; ex_mem_read = mr; ex_mul_start = ms; branch_taken = bt;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_rd = 0; ex_mem_read = 0; ex_mul_start = 0; branch_taken = 0;

    step(1, 4'd3, 4'd3, 1, 4'd3, 1, 1, 1);  lit("reset_out", 6'b000000);
    step(1, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0);  lit("reset_out2", 6'b000000);
    idle();                                 lit("post_reset", 6'b000000);

    step(0, 4'd3, 4'd0, 0, 4'd3, 1, 0, 0);  lit("load_use_rs", 6'b110100);
    idle();                                 lit("load_use_clear", 6'b000000);
    step(0, 4'd0, 4'd0, 1, 4'd0, 1, 0, 0);  lit("zero_reg", 6'b000000);

    step(0, 4'd1, 4'd5, 0, 4'd5, 1, 0, 0);  lit("rt_ungated", 6'b000000);
    step(0, 4'd1, 4'd5, 1, 4'd5, 1, 0, 0);  lit("rt_gated", 6'b110100);
    step(0, 4'd3, 4'd0, 0, 4'd3, 0, 0, 0);  lit("not_load", 6'b000000);

    step(0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 0);  lit("mul_c1", 6'b111001);
    idle();                                 lit("mul_c2", 6'b111001);
    step(0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 0);  lit("mul_c3_restart", 6'b111001);
    step(0, 4'd3, 4'd0, 0, 4'd3, 1, 0, 0);  lit("mul_c4_lu_ignored", 6'b111001);
    idle();                                 lit("mul_done", 6'b000000);
    idle();                                 lit("mul_done2", 6'b000000);

    step(0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 0);  lit("bmul_c1", 6'b111001);
    step(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1);  lit("bmul_c2_branch", 6'b111001);
    idle();                                 lit("bmul_c3", 6'b111001);
    idle();                                 lit("bmul_c4", 6'b111001);
    step(0, 4'd3, 4'd0, 0, 4'd3, 1, 1, 0);  lit("bmul_exit_flush", 6'b000110);
    idle();                                 lit("bmul_after", 6'b000000);

    step(0, 4'd3, 4'd0, 0, 4'd3, 1, 1, 1);  lit("simul_branch_wins", 6'b000110);
    idle();                                 lit("simul_no_busy", 6'b000000);

    step(0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 0);  lit("rmul_c1", 6'b111001);
    step(0, 4'd0, 4'd0, 0, 4'd0, 0, 0, 1);  lit("rmul_c2_branch", 6'b111001);
    step(1, 4'd0, 4'd0, 0, 4'd0, 0, 0, 0);  lit("rmul_c3_rst", 6'b000000);
    idle();                                 lit("rmul_no_flush", 6'b000000);
    idle();                                 lit("rmul_idle", 6'b000000);

    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 99) < 2),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom),
           4'($urandom_range(0, 3)), ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 12));
    end

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
